bt_rain_msg_sequencer: RTL and testbench
========================================

// Module: bt_rain_msg_sequencer
// PURPOSE
//  Sequences rain-status reports onto the Bluetooth UART transmitter (HC-06 link, 9600 baud).
//  Debounces the 2-bit rain level and builds the 8-byte ASCII frame "RAIN=<d>\r\n" (d = '0'..'3').
//  Feeds the frame byte-by-byte through the tx_en/tx_done handshake, on a level change or a heartbeat timeout.
//  Sits between the rain sensor logic and the UART TX / baud generator pair; it is the only driver of TxData/TxEn.
// PARAMETERS
//  HB_CYCLES      50_000_000  heartbeat period in Clk cycles (1 s at 50 MHz); min 2
//  STABLE_CYCLES  1_000_000   cycles rain_level must hold before it counts as a change (20 ms at 50 MHz); min 1
//  CNT_W          26          width of both counters; must hold max(HB_CYCLES, STABLE_CYCLES)
// PORTS
//  Clk         in   1  system clock
//  Rst_n       in   1  reset; asynchronous assert, active-low
//  rain_level  in   2  raw rain level: 0 dry, 1 light, 2 moderate, 3 heavy; synchronous to Clk
//  force_send  in   1  one-cycle request for an immediate report
//  tx_done     in   1  one-cycle pulse from the UART TX when the stop bit of the current byte has ended
//  tx_data     out  8  byte presented to the UART TX
//  tx_en       out  1  high while tx_data is valid and a byte transfer is in progress
//  busy        out  1  high from frame start until the final tx_done
//  frame_cnt   out  8  frames completed; wraps 255->0
// BEHAVIOUR
//  Reset: tx_data=8'h00, tx_en=0, busy=0, frame_cnt=0, stable_level=0, pending=0, both counters=0, state=IDLE.
//  Debounce:
//   - stab_cnt clears whenever rain_level != candidate; candidate <= rain_level.
//   - When stab_cnt reaches STABLE_CYCLES-1 and candidate != stable_level: stable_level <= candidate and pending <= 1.
//   - A level that reverts before STABLE_CYCLES is ignored.
//  Heartbeat:
//   - hb_cnt counts every cycle; at HB_CYCLES-1 it wraps and sets pending.
//   - hb_cnt clears on every frame start, so a change-triggered frame also restarts the heartbeat.
//  force_send sets pending. Any pending sources in the same cycle merge into one frame.
//  FSM:
//   - IDLE: if pending -> LOAD; clear pending; latch snap = stable_level; idx <= 0; busy <= 1.
//   - LOAD (1 cycle): tx_data <= byte(idx, snap); tx_en <= 1 -> SEND.
//   - SEND: hold tx_data/tx_en stable until tx_done.
//     * tx_done and idx != 7: idx+1, tx_en stays 1, next byte on the following cycle via LOAD (tx_en 1 throughout).
//     * tx_done and idx == 7: tx_en <= 0, busy <= 0, frame_cnt+1 -> IDLE.
//  Byte table, idx 0..7: 'R' 8'h52, 'A' 8'h41, 'I' 8'h49, 'N' 8'h4E, '=' 8'h3D, 8'h30+snap, CR 8'h0D, LF 8'h0A.
//  Latency: pending is set at cycle N; tx_en rises at N+2 (IDLE->LOAD->SEND). Back-to-back frames add one IDLE cycle.
//  Events during a frame (level change, heartbeat, force_send):
//   - They set pending and never alter the frame in flight; snap is frozen.
//   - One follow-up frame is sent after the current one, however many events occurred.
//  tx_done outside SEND is ignored. tx_done in the same cycle as a new pending event: both take effect.
//  Reset mid-frame: immediate return to reset values; no partial-frame resume; tx_en drops asynchronously.
// STRUCTURE
//  Package bt_msg_pkg:
//   - ASCII constants MSG_R..MSG_LF and MSG_LEN=8
//   - state enum {IDLE, LOAD, SEND}
//   - function msg_byte(idx[2:0], lvl[1:0]) -> [7:0]
//  Sub-module rain_level_debouncer (rain_level, STABLE_CYCLES -> stable_level, change_pulse).
//  The FSM, heartbeat counter and frame counter live in this module.
// TESTING (bench: HB_CYCLES=200, STABLE_CYCLES=8; UART model pulses tx_done 5 cycles after each byte is accepted)
//  1 Reset, then force_send pulse, level 0 -> bytes 52 41 49 4E 3D 30 0D 0A in order; frame_cnt=1; busy low after 8th tx_done.
//  2 rain_level 0->2 held 8 cycles -> one frame ending 32 0D 0A; a 0->3->0 glitch of 5 cycles -> no frame.
//  3 Idle with no events -> frame every 200 cycles; a level-change frame at cycle 150 restarts the heartbeat (next at ~350+).
//  4 Mid-frame: level 1->3 and force_send at byte 3 -> current frame keeps '1' (8'h31); exactly one follow-up frame with 8'h33.
//  5 Rst_n low during byte 4 -> tx_en=0, busy=0, frame_cnt=0 that cycle; after release, no transmission until a new pending event.
//  6 Spurious tx_done in IDLE -> no state change. 256 forced frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/bt_msg_pkg.sv
// Shared constants, state type and frame byte lookup for the rain-status
// Bluetooth message sequencer.
package bt_msg_pkg;

  localparam int unsigned LVL_W   = 2;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned MSG_LEN = 8;

  localparam logic [BYTE_W-1:0] MSG_R  = 8'h52;
  localparam logic [BYTE_W-1:0] MSG_A  = 8'h41;
  localparam logic [BYTE_W-1:0] MSG_I  = 8'h49;
  localparam logic [BYTE_W-1:0] MSG_N  = 8'h4E;
  localparam logic [BYTE_W-1:0] MSG_EQ = 8'h3D;
  localparam logic [BYTE_W-1:0] MSG_D0 = 8'h30;
  localparam logic [BYTE_W-1:0] MSG_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] MSG_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } seq_state_e;

  // Byte idx of the frame "RAIN=<d>\r\n" for rain level lvl.
  function automatic logic [BYTE_W-1:0] msg_byte(input logic [IDX_W-1:0] idx,
                                                 input logic [LVL_W-1:0] lvl);
    logic [BYTE_W-1:0] b;
    b = MSG_R;
    case (idx)
      3'd0: b = MSG_R;
      3'd1: b = MSG_A;
      3'd2: b = MSG_I;
      3'd3: b = MSG_N;
      3'd4: b = MSG_EQ;
      3'd5: b = MSG_D0 + BYTE_W'(lvl);
      3'd6: b = MSG_CR;
      3'd7: b = MSG_LF;
      default: b = MSG_R;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bt_rain_msg_sequencer_if.sv
// Byte handshake between the message sequencer and the UART transmitter.
interface bt_rain_msg_sequencer_if;
  import bt_msg_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_en;
  logic              tx_done;

  modport master (output tx_data, output tx_en, input tx_done);
  modport slave  (input tx_data, input tx_en, output tx_done);
endinterface

// File: rtl/rain_level_debouncer.sv
// Accepts a new rain level only after it has held for STABLE_CYCLES cycles;
// pulses change_pulse for one cycle when the accepted level changes.
module rain_level_debouncer
  import bt_msg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [LVL_W-1:0] rain_level,
  output logic [LVL_W-1:0] stable_level,
  output logic             change_pulse
);

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [LVL_W-1:0] cand_q, cand_d;
  logic [LVL_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic             change_q, change_d;

  always_comb begin
    cand_d     = rain_level;
    stab_cnt_d = stab_cnt_q;
    stable_d   = stable_q;
    change_d   = 1'b0;
    if (rain_level != cand_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STAB_LAST) begin
      stab_cnt_d = stab_cnt_q + CNT_W'(1);
    end else if (cand_q != stable_q) begin
      stable_d = cand_q;
      change_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cand_q     <= '0;
      stable_q   <= '0;
      stab_cnt_q <= '0;
      change_q   <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      stab_cnt_q <= stab_cnt_d;
      change_q   <= change_d;
    end
  end

  assign stable_level = stable_q;
  assign change_pulse = change_q;

endmodule

// File: rtl/bt_rain_msg_sequencer.sv
// Sends "RAIN=<d>\r\n" byte-by-byte to the UART TX on a debounced level change,
// a heartbeat timeout or a force_send request.
module bt_rain_msg_sequencer
  import bt_msg_pkg::*;
#(
  parameter int unsigned HB_CYCLES     = 50_000_000,
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [LVL_W-1:0]        rain_level,
  input  logic                    force_send,
  bt_rain_msg_sequencer_if.master tx_if,
  output logic                    busy,
  output logic [BYTE_W-1:0]       frame_cnt
);

  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HB_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

  logic [LVL_W-1:0]  stable_level;
  logic              change_pulse;

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LVL_W-1:0]  snap_q, snap_d;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  hb_cnt_q, hb_cnt_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              hb_wrap;

  rain_level_debouncer #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_debounce (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .rain_level   (rain_level),
    .stable_level (stable_level),
    .change_pulse (change_pulse)
  );

  // Next-state, heartbeat and pending-request merge.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    tx_data_d   = tx_data_q;
    tx_en_d     = tx_en_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    hb_wrap     = (hb_cnt_q == HB_LAST);
    hb_cnt_d    = hb_wrap ? '0 : hb_cnt_q + CNT_W'(1);
    pending_d   = pending_q | change_pulse | force_send | hb_wrap;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          // Frame start: restart heartbeat; only fresh events survive as a follow-up.
          state_d   = LOAD;
          pending_d = change_pulse | force_send;
          hb_cnt_d  = '0;
          snap_d    = stable_level;
          idx_d     = '0;
          busy_d    = 1'b1;
        end
      end
      LOAD: begin
        tx_data_d = msg_byte(idx_q, snap_q);
        tx_en_d   = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        if (tx_if.tx_done) begin
          if (idx_q == IDX_LAST) begin
            tx_en_d     = 1'b0;
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + BYTE_W'(1);
            state_d     = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      pending_q   <= 1'b0;
      hb_cnt_q    <= '0;
      tx_data_q   <= '0;
      tx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      pending_q   <= pending_d;
      hb_cnt_q    <= hb_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_en_q     <= tx_en_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx_if.tx_data = tx_data_q;
  assign tx_if.tx_en   = tx_en_q;
  assign busy          = busy_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_bt_rain_msg_sequencer.sv
// Randomized scoreboard bench for bt_rain_msg_sequencer with a UART TX model.
module tb_bt_rain_msg_sequencer;

  localparam int unsigned HB  = 200;
  localparam int unsigned STB = 8;
  localparam int unsigned CW  = 26;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [1:0] rain_level = 2'd0;
  logic       force_send = 1'b0;
  logic       busy;
  logic [7:0] frame_cnt;
  logic       uart_done = 1'b0;
  logic       spur_done = 1'b0;

  bt_rain_msg_sequencer_if tx_if();
  assign tx_if.tx_done = uart_done | spur_done;

  bt_rain_msg_sequencer #(
    .HB_CYCLES     (HB),
    .STABLE_CYCLES (STB),
    .CNT_W         (CW)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .rain_level (rain_level),
    .force_send (force_send),
    .tx_if      (tx_if),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_q[$];
  int start_q[$];
  int model_frames = 0;
  int stable_lvl = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_byte(input int i, input int lvl);
    string s;
    s = $sformatf("RAIN=%0d\r\n", lvl);
    return s.getc(i);
  endfunction

  function automatic int other_lvl(input int cur);
    return (cur + int'($urandom_range(1, 3))) % 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic pulse_force();
    force_send = 1'b1;
    tick(1);
    force_send = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_done(input int n);
    int seen;
    int t;
    seen = 0;
    t = 0;
    while (seen < n && t < 400) begin
      @(posedge Clk);
      if (uart_done) seen++;
      t++;
    end
    #1;
    check("bytes_seen", 32'(seen), 32'(n));
  endtask

  task automatic set_level(input int lvl);
    if (lvl != stable_lvl) begin
      exp_q.push_back(lvl);
      rain_level = 2'(lvl);
      stable_lvl = lvl;
      wait_drain("set_level", 300);
    end
  endtask

  // Events in flight leave the current digit alone and produce one follow-up frame.
  task automatic mid_frame(input int new_lvl);
    exp_q.push_back(stable_lvl);
    pulse_force();
    wait_done(3);
    rain_level = 2'(new_lvl);
    pulse_force();
    stable_lvl = new_lvl;
    exp_q.push_back(new_lvl);
  endtask

  // UART TX model: completes each accepted byte 5 cycles later.
  initial begin : uart_model
    forever begin
      @(negedge Clk);
      if (Rst_n && tx_if.tx_en) begin
        repeat (5) @(posedge Clk);
        #1 uart_done = 1'b1;
        @(posedge Clk);
        #1 uart_done = 1'b0;
        @(posedge Clk);
      end
    end
  end

  // Monitor: assembles transmitted frames and scores them against expectations.
  initial begin : monitor
    logic [7:0] fb[$];
    logic       prev_en;
    int         lvl;
    prev_en = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        fb.delete();
        model_frames = 0;
        prev_en = 1'b0;
      end else begin
        if (tx_if.tx_en && !prev_en) start_q.push_back(cyc);
        prev_en = tx_if.tx_en;
        if (tx_if.tx_done && tx_if.tx_en) begin
          fb.push_back(tx_if.tx_data);
          if (fb.size() == 8) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_frame: got digit byte %0h, expected no frame", fb[5]);
            end else begin
              lvl = exp_q.pop_front();
              for (int i = 0; i < 8; i++)
                check($sformatf("frame%0d_byte%0d", model_frames, i), 32'(fb[i]),
                      32'(ref_byte(i, lvl)));
            end
            fb.delete();
            model_frames++;
            @(negedge Clk);
            check("busy_after_frame", 32'(busy), 32'd0);
            check("frame_cnt", 32'(frame_cnt), 32'(model_frames % 256));
            prev_en = tx_if.tx_en;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  initial begin : stim
    int base;
    int last;
    int act;
    int lvl;
    int any_en;

    // Reset values
    tick(3);
    check("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    check("rst_tx_en", 32'(tx_if.tx_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    Rst_n = 1'b1;
    tick(2);

    // Forced frame at level 0
    exp_q.push_back(0);
    pulse_force();
    wait_drain("t1", 300);

    // Short glitch ignored, then a real change to 2
    rain_level = 2'd3;
    tick(5);
    rain_level = 2'd0;
    tick(30);
    check("glitch_no_frame", 32'(start_q.size()), 32'd1);
    set_level(2);

    // Heartbeat period with no events
    base = start_q.size();
    exp_q.push_back(stable_lvl);
    exp_q.push_back(stable_lvl);
    wait_drain("hb", 800);
    check("hb_frames", 32'(start_q.size()), 32'(base + 2));
    if (start_q.size() >= base + 2) begin
      act = start_q[base + 1] - start_q[base];
      check($sformatf("hb_period_%0d", act), 32'(act >= HB && act <= HB + 1), 32'd1);
    end

    // Level change at ~150 cycles restarts the heartbeat
    last = start_q[$];
    while (cyc < last + 150) tick(1);
    base = start_q.size();
    lvl = other_lvl(stable_lvl);
    rain_level = 2'(lvl);
    stable_lvl = lvl;
    exp_q.push_back(lvl);
    exp_q.push_back(lvl);
    wait_drain("hb_restart", 800);
    check("hb_restart_frames", 32'(start_q.size()), 32'(base + 2));
    if (start_q.size() >= base + 2) begin
      act = start_q[base] - last;
      check($sformatf("change_before_hb_%0d", act), 32'(act < HB), 32'd1);
      act = start_q[base + 1] - start_q[base];
      check($sformatf("hb_after_change_%0d", act), 32'(act >= HB && act <= HB + 1), 32'd1);
    end

    // Mid-frame change 1->3 with force_send
    set_level(1);
    mid_frame(3);
    wait_drain("mid", 400);

    // Randomized mix of events
    for (int it = 0; it < 20; it++) begin
      tick(int'($urandom_range(1, 40)));
      act = int'($urandom_range(0, 3));
      case (act)
        0: begin
          exp_q.push_back(stable_lvl);
          pulse_force();
        end
        1: begin
          lvl = other_lvl(stable_lvl);
          exp_q.push_back(lvl);
          rain_level = 2'(lvl);
          stable_lvl = lvl;
        end
        2: mid_frame(int'($urandom_range(0, 3)));
        default: begin
          rain_level = 2'(other_lvl(stable_lvl));
          tick(int'($urandom_range(1, STB - 2)));
          rain_level = 2'(stable_lvl);
          tick(5);
          exp_q.push_back(stable_lvl);
          pulse_force();
        end
      endcase
      wait_drain($sformatf("rand%0d", it), 500);
    end

    // Reset during byte 4
    set_level(0);
    exp_q.push_back(0);
    pulse_force();
    wait_done(4);
    tick(2);
    #2 Rst_n = 1'b0;
    #1;
    check("midrst_tx_en", 32'(tx_if.tx_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    exp_q.delete();
    tick(2);
    Rst_n = 1'b1;
    any_en = 0;
    for (int i = 0; i < 150; i++) begin
      if (tx_if.tx_en || busy) any_en = 1;
      tick(1);
    end
    check("no_tx_after_reset", 32'(any_en), 32'd0);

    // Spurious tx_done in IDLE
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    tick(3);
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_tx_en", 32'(tx_if.tx_en), 32'd0);
    check("spur_frame_cnt", 32'(frame_cnt), 32'd0);

    // 256 forced frames wrap frame_cnt
    for (int f = 0; f < 256; f++) begin
      exp_q.push_back(stable_lvl);
      pulse_force();
      wait_drain("wrap", 300);
      tick(int'($urandom_range(1, 10)));
    end
    check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

    tick(20);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
